// File: rtl/dram_port_responder_if.sv
// Core-side DRAM port bundle: request strobes/address/data from the core,
// busy/odata/misaligned back from the responder.
interface dram_port_responder_if;
   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_we_t;
   logic        w_dram_le;
   logic [2:0]  w_dram_ctrl;
   logic        w_dram_busy;
   logic [31:0] w_dram_odata;
   logic        r_misaligned;

   modport master (
      output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
      input  w_dram_busy, w_dram_odata, r_misaligned
   );

   modport slave (
      input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
      output w_dram_busy, w_dram_odata, r_misaligned
   );
endinterface

// File: rtl/dram_port_responder.sv
// Memory-side responder for a core DRAM port. Serves single-cycle load/store
// strobes from an on-chip synchronous RAM with byte lanes, sign/zero extension
// and a programmable wait to mimic external DRAM latency.
module dram_port_responder #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned LATENCY    = 2
) (
   input logic                  clk,
   input logic                  rst,
   dram_port_responder_if.slave dram
);

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

   localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
   localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic [31:0]           odata_q, odata_d;
   logic                  mis_q, mis_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            ctrl_q, ctrl_d;
   logic                  store_q, store_d;

   // RAM has no reset: contents survive rst.
   logic [31:0]           mem_q [Depth];
   logic [31:0]           rdata_q;

   logic                  mem_we;
   logic                  mem_re;
   logic [3:0]            be;
   logic [31:0]           wlanes;
   logic                  misaligned;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           load_val;
   logic [ADDR_WIDTH-1:0] word_idx;

   // Address bits above the RAM span wrap and are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^dram.w_dram_addr[31:ADDR_WIDTH+2];

   assign word_idx = addr_q[ADDR_WIDTH+1:2];

   // Store lane/byte-enable steering and alignment check from the latched request.
   always_comb begin
      be         = 4'b1111;
      wlanes     = wdata_q;
      misaligned = 1'b0;
      case (ctrl_q[1:0])
         2'b00: begin
            be     = 4'b0001 << addr_q[1:0];
            wlanes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be         = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes     = {2{wdata_q[15:0]}};
            misaligned = addr_q[0];
         end
         // 10 is word; 11 (undefined) is treated as word too.
         default: misaligned = (addr_q[1:0] != 2'b00);
      endcase
   end

   // Load lane select and sign/zero extension of the RAM read word.
   always_comb begin
      ld_byte  = 8'h00;
      ld_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      load_val = rdata_q;
      unique case (addr_q[1:0])
         2'b00: ld_byte = rdata_q[7:0];
         2'b01: ld_byte = rdata_q[15:8];
         2'b10: ld_byte = rdata_q[23:16];
         2'b11: ld_byte = rdata_q[31:24];
         default: ld_byte = 8'h00;
      endcase
      case (ctrl_q[1:0])
         2'b00:   load_val = ctrl_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_val = ctrl_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_val = rdata_q;
      endcase
      if (misaligned) begin
         load_val = 32'h0;
      end
   end

   // Request FSM: accept, wait LATENCY cycles, touch the RAM, then retire.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      odata_d = odata_q;
      mis_d   = mis_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ctrl_d  = ctrl_q;
      store_d = store_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dram.w_dram_we_t || dram.w_dram_le) begin
               addr_d  = dram.w_dram_addr[ADDR_WIDTH+1:0];
               wdata_d = dram.w_dram_wdata;
               ctrl_d  = dram.w_dram_ctrl;
               // Store wins when both strobes arrive together.
               store_d = dram.w_dram_we_t;
               busy_d  = 1'b1;
               cnt_d   = CntLoad;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StAccess;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StAccess: begin
            mem_we  = store_q & ~misaligned;
            mem_re  = ~store_q;
            if (misaligned) begin
               mis_d = 1'b1;
            end
            state_d = StDone;
         end
         StDone: begin
            if (!store_q) begin
               odata_d = load_val;
            end
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and request registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         odata_q <= 32'h0;
         mis_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         ctrl_q  <= 3'b000;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         odata_q <= odata_d;
         mis_q   <= mis_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ctrl_q  <= ctrl_d;
         store_q <= store_d;
      end
   end

   // Synchronous RAM with per-byte write enables and registered read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
         end
      end
      if (mem_re) begin
         rdata_q <= mem_q[word_idx];
      end
   end

   assign dram.w_dram_busy  = busy_q;
   assign dram.w_dram_odata = odata_q;
   assign dram.r_misaligned = mis_q;

endmodule

// File: tb/tb_dram_port_responder.sv
// Self-checking bench for dram_port_responder: directed steps followed by a
// randomized phase checked against a byte-addressed reference memory.
module tb_dram_port_responder;

   localparam int unsigned AW   = 14;
   localparam int unsigned LAT  = 2;
   localparam int unsigned SPAN = 1 << (AW + 2);
   localparam int          BUSY_CYC = LAT + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dram_port_responder_if dram ();

   dram_port_responder #(
      .ADDR_WIDTH(AW),
      .LATENCY   (LAT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .dram(dram)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [7:0]  ref_mem [int unsigned];
   logic [31:0] ref_odata;
   logic        ref_mis;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      dram.w_dram_we_t = 1'b0;
      dram.w_dram_le   = 1'b0;
   endtask

   // Called at a negedge with the responder idle. Optionally fires a second
   // store strobe while busy. Returns busy-high cycle count and final odata.
   task automatic access(input logic we, input logic le, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl, input bit intrude,
                         output int n, output logic [31:0] od);
      dram.w_dram_we_t  = we;
      dram.w_dram_le    = le;
      dram.w_dram_addr  = addr;
      dram.w_dram_wdata = wdata;
      dram.w_dram_ctrl  = ctrl;
      @(negedge clk);
      if (intrude) begin
         dram.w_dram_we_t  = 1'b1;
         dram.w_dram_le    = 1'b0;
         dram.w_dram_addr  = 32'h0000_0108;
         dram.w_dram_wdata = 32'hFFFF_FFFF;
         dram.w_dram_ctrl  = 3'b010;
      end else begin
         idle_inputs();
      end
      n = 0;
      while (dram.w_dram_busy === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
         idle_inputs();
      end
      od = dram.w_dram_odata;
   endtask

   // Spec-level model of one accepted request.
   task automatic model_access(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] ctrl);
      int unsigned size;
      bit          sgn;
      int unsigned ba;
      logic [31:0] val;
      ba = addr % SPAN;
      if (we) begin
         size = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
         sgn  = 1'b0;
      end else begin
         case (ctrl)
            3'b000:  begin size = 1; sgn = 1'b1; end
            3'b001:  begin size = 2; sgn = 1'b1; end
            3'b100:  begin size = 1; sgn = 1'b0; end
            3'b101:  begin size = 2; sgn = 1'b0; end
            default: begin size = 4; sgn = 1'b0; end
         endcase
      end
      if ((ba % size) != 0) begin
         ref_mis = 1'b1;
         if (!we) ref_odata = 32'h0;
      end else if (we) begin
         for (int i = 0; i < int'(size); i++) ref_mem[ba + i] = wdata[8*i +: 8];
      end else begin
         val = 32'h0;
         for (int i = 0; i < int'(size); i++) val = val + (32'(ref_mem[ba + i]) << (8 * i));
         if (sgn && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
         ref_odata = val;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [31:0] od;
      logic        we, le;
      logic [31:0] addr, wdata;
      logic [2:0]  ctrl;
      int unsigned op;

      idle_inputs();
      dram.w_dram_addr  = 32'h0;
      dram.w_dram_wdata = 32'h0;
      dram.w_dram_ctrl  = 3'b000;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(dram.w_dram_busy), 32'h0);
      check("rst_odata", dram.w_dram_odata, 32'h0);
      check("rst_mis", 32'(dram.r_misaligned), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Word store then word load.
      access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, n, od);
      check("st_word_busy", 32'(n), 32'(BUSY_CYC));
      check("st_keeps_odata", od, 32'h0);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("ld_word_busy", 32'(n), 32'(BUSY_CYC));
      check("ld_word", od, 32'hDEAD_BEEF);

      // Byte and half extension.
      access(1'b0, 1'b1, 32'h101, 32'h0, 3'b000, 1'b0, n, od);
      check("ld_byte_s", od, 32'hFFFF_FFBE);
      access(1'b0, 1'b1, 32'h101, 32'h0, 3'b100, 1'b0, n, od);
      check("ld_byte_u", od, 32'h0000_00BE);
      access(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, 1'b0, n, od);
      check("ld_half_s", od, 32'hFFFF_DEAD);
      access(1'b0, 1'b1, 32'h102, 32'h0, 3'b101, 1'b0, n, od);
      check("ld_half_u", od, 32'h0000_DEAD);

      // Sub-word stores.
      access(1'b1, 1'b0, 32'h103, 32'hAB12_3412, 3'b000, 1'b0, n, od);
      check("st_byte_odata_held", od, 32'h0000_DEAD);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("st_byte_merge", od, 32'h12AD_BEEF);
      access(1'b1, 1'b0, 32'h100, 32'h7777_5566, 3'b001, 1'b0, n, od);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("st_half_merge", od, 32'h12AD_5566);
      check("mis_clear", 32'(dram.r_misaligned), 32'h0);

      // Misaligned accesses.
      access(1'b0, 1'b1, 32'h101, 32'h0, 3'b001, 1'b0, n, od);
      check("mis_ld_busy", 32'(n), 32'(BUSY_CYC));
      check("mis_ld_zero", od, 32'h0);
      check("mis_set", 32'(dram.r_misaligned), 32'h1);
      access(1'b1, 1'b0, 32'h102, 32'hAAAA_AAAA, 3'b010, 1'b0, n, od);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("mis_st_no_write", od, 32'h12AD_5566);
      check("mis_sticky", 32'(dram.r_misaligned), 32'h1);

      // Both strobes, mid-busy strobe, address wrap.
      access(1'b1, 1'b0, 32'h108, 32'h0102_0304, 3'b010, 1'b0, n, od);
      access(1'b0, 1'b1, 32'h108, 32'h0, 3'b010, 1'b0, n, od);
      check("ld_108", od, 32'h0102_0304);
      access(1'b1, 1'b1, 32'h0001_0100, 32'h0BAD_F00D, 3'b010, 1'b1, n, od);
      check("both_busy", 32'(n), 32'(BUSY_CYC));
      check("both_load_dropped", od, 32'h0102_0304);
      access(1'b0, 1'b1, 32'h108, 32'h0, 3'b010, 1'b0, n, od);
      check("midbusy_ignored", od, 32'h0102_0304);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("wrap_store", od, 32'h0BAD_F00D);

      // Reset during WAIT of a store.
      dram.w_dram_we_t  = 1'b1;
      dram.w_dram_addr  = 32'h100;
      dram.w_dram_wdata = 32'h1111_1111;
      dram.w_dram_ctrl  = 3'b010;
      @(negedge clk);
      idle_inputs();
      check("wait_busy", 32'(dram.w_dram_busy), 32'h1);
      #1 rst = 1'b1;
      #1 check("rst_async_busy", 32'(dram.w_dram_busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mis_cleared", 32'(dram.r_misaligned), 32'h0);
      check("rst_odata_cleared", dram.w_dram_odata, 32'h0);
      @(negedge clk);
      access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1'b0, n, od);
      check("post_rst_busy", 32'(n), 32'(BUSY_CYC));
      check("post_rst_discard", od, 32'h0BAD_F00D);

      // Randomized phase against the reference model.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ref_odata = 32'h0;
      ref_mis   = 1'b0;
      @(negedge clk);
      for (int w = 0; w < 8; w++) begin
         addr  = 32'h800 + 32'(4 * w);
         wdata = $urandom();
         model_access(1'b1, addr, wdata, 3'b010);
         access(1'b1, 1'b0, addr, wdata, 3'b010, 1'b0, n, od);
         check("init_odata", od, ref_odata);
      end
      for (int k = 0; k < 60; k++) begin
         op    = $urandom_range(0, 2);
         we    = (op != 1);
         le    = (op != 0);
         addr  = ($urandom() & 32'hFFFF_0000) | (32'h800 + 32'($urandom_range(0, 31)));
         wdata = $urandom();
         ctrl  = 3'($urandom_range(0, 7));
         model_access(we, addr, wdata, ctrl);
         access(we, le, addr, wdata, ctrl, 1'b0, n, od);
         check("rnd_busy", 32'(n), 32'(BUSY_CYC));
         check("rnd_odata", od, ref_odata);
         check("rnd_mis", 32'(dram.r_misaligned), 32'(ref_mis));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
